// File: rtl/sfifo_prog_pkg.sv
// Shared definitions for the single-clock programmable FIFO.
//   FIFO_MODE_STD  : registered read data, one cycle read latency
//   FIFO_MODE_FWFT : head word visible combinationally (first-word-fall-through)
//   fifo_depth()   : entry count derived from the address width
package sfifo_prog_pkg;

  localparam int unsigned FIFO_MODE_STD  = 0;
  localparam int unsigned FIFO_MODE_FWFT = 1;

  function automatic int unsigned fifo_depth(input int unsigned asize);
    return 32'(1) << asize;
  endfunction

endpackage

// File: rtl/sfifo_mem.sv
// DEPTH x DSIZE simple dual-port storage for sfifo_prog.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset (read register only)
//   i_we/i_waddr/i_wdata : synchronous write port with enable
//   i_re/i_raddr      : read enable (standard mode) and read address
//   o_rdata           : registered (FWFT=0) or combinational (FWFT=1) read data
module sfifo_mem
  import sfifo_prog_pkg::*;
#(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned ASIZE = 4,
  parameter int unsigned FWFT  = FIFO_MODE_STD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic [ASIZE-1:0] i_waddr,
  input  logic [DSIZE-1:0] i_wdata,
  input  logic             i_re,
  input  logic [ASIZE-1:0] i_raddr,
  output logic [DSIZE-1:0] o_rdata
);

  localparam int unsigned DEPTH = fifo_depth(ASIZE);

  logic [DSIZE-1:0] r_mem [DEPTH];

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      // Head word falls through; read enable and reset have no role here.
      logic w_unused;
      assign w_unused = i_re ^ rst_n;
      assign o_rdata  = r_mem[i_raddr];
    end else begin : g_std
      logic [DSIZE-1:0] r_rdata;
      // Output register holds its value between accepted reads.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_rdata <= '0;
        end else if (i_re) begin
          r_rdata <= r_mem[i_raddr];
        end
      end
      assign o_rdata = r_rdata;
    end
  endgenerate

endmodule

// File: rtl/sfifo_prog.sv
// Single-clock synchronous FIFO with occupancy count, programmable
// almost-full/almost-empty flags, standard or FWFT read mode, synchronous
// flush and sticky overflow/underflow flags.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   flush               : clears contents and error flags, beats winc/rinc
//   winc/wdata, wfull   : write request/data, full flag
//   rinc/rdata, rempty  : read request/data, empty flag
//   af_thresh/ae_thresh : almost-full / almost-empty thresholds
//   walmost_full        : count >= af_thresh
//   ralmost_empty       : count <= ae_thresh
//   count               : occupancy 0..DEPTH
//   overflow/underflow  : sticky error flags
module sfifo_prog
  import sfifo_prog_pkg::*;
#(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned ASIZE = 4,
  parameter int unsigned FWFT  = FIFO_MODE_STD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty,
  input  logic [ASIZE:0]   af_thresh,
  input  logic [ASIZE:0]   ae_thresh,
  output logic             walmost_full,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned DEPTH = fifo_depth(ASIZE);
  localparam int unsigned PW    = ASIZE + 1;

  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW-1:0] r_count;
  logic          r_wfull;
  logic          r_rempty;
  logic          r_afull;
  logic          r_aempty;
  logic          r_ovf;
  logic          r_udf;

  logic          w_wacc;
  logic          w_racc;
  logic [PW-1:0] w_cnt_nxt;

  // Accepts use the current registered flags; flush suppresses both sides.
  assign w_wacc = winc & ~r_wfull  & ~flush;
  assign w_racc = rinc & ~r_rempty & ~flush;

  always_comb begin
    w_cnt_nxt = r_count + PW'(w_wacc) - PW'(w_racc);
  end

  // Pointers, occupancy and flags; flags track count_next so they move with count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_wfull  <= 1'b0;
      r_rempty <= 1'b1;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else if (flush) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_wfull  <= 1'b0;
      r_rempty <= 1'b1;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_wacc) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_racc) begin
        r_rptr <= r_rptr + PW'(1);
      end
      r_count  <= w_cnt_nxt;
      r_wfull  <= (w_cnt_nxt == PW'(DEPTH));
      r_rempty <= (w_cnt_nxt == '0);
      r_afull  <= (w_cnt_nxt >= af_thresh);
      r_aempty <= (w_cnt_nxt <= ae_thresh);
      r_ovf    <= r_ovf | (winc & r_wfull);
      r_udf    <= r_udf | (rinc & r_rempty);
    end
  end

  sfifo_mem #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE),
    .FWFT  (FWFT)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_wacc),
    .i_waddr (r_wptr[ASIZE-1:0]),
    .i_wdata (wdata),
    .i_re    (w_racc),
    .i_raddr (r_rptr[ASIZE-1:0]),
    .o_rdata (rdata)
  );

  assign wfull         = r_wfull;
  assign rempty        = r_rempty;
  assign walmost_full  = r_afull;
  assign ralmost_empty = r_aempty;
  assign count         = r_count;
  assign overflow      = r_ovf;
  assign underflow     = r_udf;

endmodule

// File: doc/sfifo_prog.md
Name: sfifo_prog

Overview:
Single-clock, parametrised synchronous FIFO. It is the next generation of the team's async FIFO, for paths where both sides share one clock. Relative to the async FIFO it adds:
- an occupancy count,
- runtime-programmable almost-full and almost-empty flags,
- standard or first-word-fall-through (FWFT) read mode,
- synchronous flush,
- sticky overflow/underflow error flags.

It sits between a producer and a consumer inside one clock domain and uses the same winc/rinc/wfull/rempty handshake as the async FIFO.

Parameters:
DSIZE, 8, data width in bits
ASIZE, 4, address width; DEPTH = 2**ASIZE entries
FWFT, 0, read mode: 0 = standard (registered rdata, 1-cycle latency), 1 = first-word-fall-through

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  reset, synchronous, active-low
flush  input  1  synchronous clear of FIFO contents and error flags
winc  input  1  write request
wdata  input  DSIZE  write data
rinc  input  1  read request
rdata  output  DSIZE  read data
wfull  output  1  FIFO full (count == DEPTH)
rempty  output  1  FIFO empty (count == 0)
af_thresh  input  ASIZE+1  almost-full threshold
ae_thresh  input  ASIZE+1  almost-empty threshold
walmost_full  output  1  count >= af_thresh
ralmost_empty  output  1  count <= ae_thresh
count  output  ASIZE+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: a write was attempted while full
underflow  output  1  sticky: a read was attempted while empty

Behaviour:
- One clock: clk. Reset is synchronous and active-low: rst_n is sampled on the rising edge of clk.
- Reset values:
  - wptr/rptr = 0, count = 0
  - rempty = 1, wfull = 0
  - walmost_full = 0, ralmost_empty = 1
  - overflow = underflow = 0, rdata = 0
  - Memory contents are not reset.
- Pointers:
  - ASIZE+1-bit binary; the low ASIZE bits address memory.
  - The MSB toggles on wrap-around; wraps naturally modulo 2*DEPTH.
- Accept rules (evaluated on the current-cycle flags):
  - w_acc = winc & ~wfull
  - r_acc = rinc & ~rempty
  - A write while full is dropped, even if a read is accepted in the same cycle.
  - A read while empty is dropped, even if a write is accepted in the same cycle.
- Count update:
  - count_next = count + w_acc - r_acc.
  - Simultaneous accepted write and read leaves count unchanged; both pointers advance.
- Flag timing:
  - All flags are registered, computed from count_next, so they change on the same edge as count.
  - wfull = (count_next == DEPTH), rempty = (count_next == 0).
  - walmost_full = (count_next >= af_thresh), ralmost_empty = (count_next <= ae_thresh).
  - Thresholds are sampled every cycle and may change at runtime. A change takes effect on the next edge.
  - af_thresh = 0 forces walmost_full = 1 from the first edge after reset onward. ae_thresh >= DEPTH forces ralmost_empty = 1.
- Write: on w_acc, mem[wptr[ASIZE-1:0]] <= wdata and wptr increments.
- Read, FWFT = 0:
  - On r_acc, rdata <= mem[rptr[ASIZE-1:0]] and rptr increments.
  - Read latency is 1 cycle; rdata holds its value otherwise.
- Read, FWFT = 1:
  - rdata = mem[rptr[ASIZE-1:0]] combinationally; the head word is visible whenever rempty = 0.
  - On r_acc, rptr increments and rdata shows the next word after the edge.
  - rdata is don't-care while rempty = 1.
- Write-to-read when empty:
  - A word written at edge N sets rempty = 0 after edge N.
  - FWFT: rdata is valid in the cycle after edge N.
  - Standard: rinc is accepted in the cycle after edge N; data appears after the following edge.
- Errors:
  - overflow is set on winc & wfull; underflow is set on rinc & rempty.
  - Both stay set until rst_n = 0 or flush = 1.
- Flush:
  - Has priority over winc/rinc in that cycle; those requests are ignored and do not set error flags.
  - Next state: wptr = rptr = 0, count = 0, flags as at reset, overflow = underflow = 0.
  - rdata in standard mode is unchanged.
- Reset priority: rst_n = 0 overrides flush, winc and rinc. Reset mid-operation discards all content at that edge.

Decomposition:
- Shared package/header: read-mode encodings (FIFO_MODE_STD = 0, FIFO_MODE_FWFT = 1) and the DEPTH derivation from ASIZE.
- One sub-module: sfifo_mem, a DEPTH x DSIZE simple dual-port memory.
  - Write port is synchronous with enable.
  - Read port is registered or combinational, selected by FWFT.
- Pointer, count, flag and error logic live in sfifo_prog.

Test Plan (DSIZE = 8, ASIZE = 2 so DEPTH = 4; af_thresh = 3, ae_thresh = 1):
1. Reset and fill: rst_n = 0 for 2 cycles, then write 0x11, 0x22, 0x33, 0x44 -> count 1,2,3,4; ralmost_empty drops after the 2nd write; walmost_full rises after the 3rd; wfull = 1 after the 4th; overflow = 0.
2. Overflow: while full, winc with 0x55 -> count stays 4, overflow = 1 and sticky. Drain 4 words -> reads 0x11, 0x22, 0x33, 0x44 with 1-cycle latency; 0x55 is never read.
3. Underflow: rinc while empty -> rdata holds 0x44, count stays 0, underflow = 1. flush -> underflow = 0.
4. Simultaneous ops: at count = 4, assert winc + rinc -> write dropped, read accepted, count = 3. At count = 2, assert both -> count stays 2, order preserved. At count = 0, assert both -> write accepted, read dropped, count = 1.
5. Wrap-around and FWFT: FWFT = 1, stream 10 words 0x01..0x0A with interleaved reads -> rdata equals the head whenever rempty = 0, order preserved across 2 pointer wraps.
6. Flush/reset mid-operation: count = 3, flush together with winc -> count = 0, rempty = 1, no overflow. Refill 2 words, then rst_n = 0 for one edge -> all outputs at reset values.
